baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 132 +++++++++++++
 tb/tb_baud_gen_frac.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: os_tick every div_int(+frac) cycles, bit_tick every OSR os_ticks.
// Optional fractional accumulator enabled by macro BAUD_GEN_FRAC_EN.
module baud_gen_frac #(
    parameter int CNT_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OSR        = 16,
    parameter int RESET_DIV  = 325,
    parameter int RESET_FRAC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              bit_tick
);

    localparam int OS_W = (OSR > 2) ? $clog2(OSR) : 1;

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pdiv;
    logic [OS_W-1:0]  r_os_cnt;
    logic             r_pending;
    logic             r_os_tick;
    logic             r_bit_tick;

    logic             w_carry;
    logic [CNT_W:0]   w_len;
    logic             w_term;
    logic             w_accept;
    logic             w_apply;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] r_frac;
    logic [FRAC_W-1:0] r_pfrac;
    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W:0]   w_sum;

    // The carry of this period's add stretches the period now being timed.
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_frac};
    assign w_carry = w_sum[FRAC_W];
`else
    logic w_unused_frac;

    assign w_carry       = 1'b0;
    assign w_unused_frac = ^{div_frac, FRAC_W'(RESET_FRAC)};
`endif

    assign w_len    = {1'b0, r_div} + {{CNT_W{1'b0}}, w_carry};
    // >= rather than == so a smaller divisor applied while frozen still terminates.
    assign w_term   = en && (({1'b0, r_cnt} + (CNT_W+1)'(1)) >= w_len);
    assign w_accept = cfg_valid && !r_pending;
    assign w_apply  = r_pending && (restart || !en || w_term);

    assign cfg_ready = !r_pending;
    assign os_tick   = r_os_tick;
    assign bit_tick  = r_bit_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= clamp_div(CNT_W'(RESET_DIV));
            r_cnt      <= '0;
            r_pdiv     <= '0;
            r_os_cnt   <= '0;
            r_pending  <= 1'b0;
            r_os_tick  <= 1'b0;
            r_bit_tick <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            r_frac     <= FRAC_W'(RESET_FRAC);
            r_pfrac    <= '0;
            r_acc      <= '0;
`endif
        end else begin
            // NOTE: later non-blocking assignments in this block win, so the
            // defaults and the apply/restart overrides below rely on ordering.
            r_os_tick  <= 1'b0;
            r_bit_tick <= 1'b0;

            if (w_accept) begin
                r_pending <= 1'b1;
                r_pdiv    <= div_int;
`ifdef BAUD_GEN_FRAC_EN
                r_pfrac   <= div_frac;
`endif
            end

            if (restart) begin
                r_cnt    <= '0;
                r_os_cnt <= '0;
`ifdef BAUD_GEN_FRAC_EN
                r_acc    <= '0;
`endif
            end else if (en) begin
                if (w_term) begin
                    r_cnt     <= '0;
                    r_os_tick <= 1'b1;
`ifdef BAUD_GEN_FRAC_EN
                    r_acc     <= w_sum[FRAC_W-1:0];
`endif
                    if (r_os_cnt == OS_W'(OSR - 1)) begin
                        r_os_cnt   <= '0;
                        r_bit_tick <= 1'b1;
                    end else begin
                        r_os_cnt <= r_os_cnt + OS_W'(1);
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // Accept needs !r_pending, so it never coincides with an apply.
            if (w_apply) begin
                r_div     <= clamp_div(r_pdiv);
                r_pending <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
                r_frac    <= r_pfrac;
                r_acc     <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed tick-spacing scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_baud_gen_frac;

    localparam int CNT_W = 16;
    localparam int FRAC_W = 4;
    localparam int OSR = 4;
    localparam int RDIV = 4;
    localparam int FRAC_MOD = 1 << FRAC_W;
`ifdef BAUD_GEN_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              restart;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              os_tick;
    logic              bit_tick;

    int n_checks = 0;
    int n_errors = 0;

    int os_q[$];
    int bit_q[$];

    // Behavioural model state: divisor, fraction, accumulator, cycles elapsed in period.
    int m_div, m_frac, m_acc, m_el, m_os, m_pdiv, m_pfrac;
    bit m_pend;
    bit e_os, e_bit, e_rdy;

    baud_gen_frac #(
        .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR(OSR), .RESET_DIV(RDIV), .RESET_FRAC(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .div_int(div_int), .div_frac(div_frac),
        .os_tick(os_tick), .bit_tick(bit_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_div = RDIV; m_frac = 0; m_acc = 0; m_el = 0; m_os = 0;
        m_pdiv = 0; m_pfrac = 0; m_pend = 0;
        e_os = 0; e_bit = 0; e_rdy = 1;
    endtask

    // Predicts outputs after the coming edge from the current inputs and model state.
    task automatic model_step(input bit e, input bit r, input bit v, input int d, input int f);
        int len;
        bit pend_end, apply, accept;
        len = m_div + ((FRAC_ON && (m_acc + m_frac >= FRAC_MOD)) ? 1 : 0);
        pend_end = e && !r && (m_el + 1 >= len);
        accept = v && !m_pend;
        apply = m_pend && (r || !e || pend_end);
        e_os = 0;
        e_bit = 0;
        if (r) begin
            m_el = 0; m_os = 0; m_acc = 0;
        end else if (e) begin
            if (pend_end) begin
                m_el = 0;
                m_acc = (m_acc + m_frac) % FRAC_MOD;
                m_os = (m_os + 1) % OSR;
                e_os = 1;
                e_bit = (m_os == 0);
            end else begin
                m_el++;
            end
        end
        if (apply) begin
            m_div = (m_pdiv < 2) ? 2 : m_pdiv;
            m_frac = m_pfrac;
            m_acc = 0;
            m_pend = 0;
        end
        if (accept) begin
            m_pend = 1; m_pdiv = d; m_pfrac = f;
        end
        e_rdy = !m_pend;
    endtask

    task automatic cyc(input bit e, input bit r, input bit v, input int d, input int f);
        en = e; restart = r; cfg_valid = v;
        div_int = CNT_W'(d); div_frac = FRAC_W'(f);
        model_step(e, r, v, d, f);
        @(posedge clk);
        #1;
        check("model_os_tick", os_tick, e_os);
        check("model_bit_tick", bit_tick, e_bit);
        check("model_cfg_ready", cfg_ready, e_rdy);
    endtask

    task automatic run(input int n);
        os_q.delete();
        bit_q.delete();
        for (int i = 1; i <= n; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (os_tick) os_q.push_back(i);
            if (bit_tick) bit_q.push_back(i);
        end
    endtask

    // Offer a divisor, then restart so it applies with counters realigned.
    task automatic set_div(input int d, input int f);
        cyc(1, 0, 1, d, f);
        cyc(1, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; restart = 1'b0; cfg_valid = 1'b0;
        div_int = '0; div_frac = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_os_tick", os_tick, 0);
        check("reset_bit_tick", bit_tick, 0);
        check("reset_cfg_ready", cfg_ready, 1);
        rst = 1'b0;

        // Reset divisor 4, OSR 4: os_tick every 4 cycles, bit_tick every 16.
        run(64);
        check("a_os_count", os_q.size(), 16);
        check("a_first_os", os_q[0], 4);
        check("a_last_os", os_q[15], 64);
        check("a_bit_count", bit_q.size(), 4);
        check("a_first_bit", bit_q[0], 16);

        // div 4 + 8/16: 4,5 alternation with the fraction compiled in.
        set_div(4, 8);
        run(80);
        check("b_16th_os", os_q[15], FRAC_ON ? 72 : 64);
        check("b_second_gap", os_q[1] - os_q[0], FRAC_ON ? 5 : 4);

        // div 6 offered mid-period waits for the current period to end.
        set_div(4, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 6, 0);
        check("c_ready_low", cfg_ready, 0);
        cyc(1, 0, 0, 0, 0);
        check("c_ready_still_low", cfg_ready, 0);
        cyc(1, 0, 0, 0, 0);
        check("c_boundary_os", os_tick, 1);
        check("c_ready_back", cfg_ready, 1);
        run(12);
        check("c_first_6", os_q[0], 6);
        check("c_second_6", os_q[1], 12);

        // Restart mid-period, then restart on a terminal cycle.
        set_div(4, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("d_restart_no_tick", os_tick, 0);
        run(4);
        check("d_os_after_restart", os_q[0], 4);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("d_restart_suppress", os_tick, 0);
        run(16);
        check("d_os_realigned", os_q[0], 4);
        check("d_bit_realigned", bit_q[0], 16);

        // Freeze: en=0 holds the count and silences ticks.
        set_div(4, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (3) begin
            cyc(0, 0, 0, 0, 0);
            check("e_frozen_os", os_tick, 0);
        end
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("e_resume_os", os_tick, 1);

        // rst mid-count at div 6 with a divisor pending from the terminal cycle.
        set_div(6, 0);
        repeat (5) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 9, 0);
        check("f_tick_before_rst", os_tick, 1);
        check("f_pending_after_end", cfg_ready, 0);
        rst = 1'b1;
        #1;
        check("f_rst_os", os_tick, 0);
        check("f_rst_bit", bit_tick, 0);
        check("f_rst_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run(8);
        check("f_resume_first", os_q[0], 4);
        check("f_resume_second", os_q[1], 8);

        // div_int=1 clamps to 2-cycle periods.
        set_div(1, 0);
        run(8);
        check("g_clamp_count", os_q.size(), 4);
        check("g_clamp_first", os_q[0], 2);
        check("g_clamp_last", os_q[3], 8);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)),
                int'($urandom_range(0, FRAC_MOD - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
